// File: rtl/seg_disp_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package seg_disp_pkg;

    localparam logic [3:0] BLANK_NIBBLE = 4'hf;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    // Turns a latched value into the four nibbles sent to the driver.
    // The OFF blink phase blanks everything. Otherwise, leading zeros are
    // optionally blanked from the top digit down. Digit one is always shown.
    function automatic logic [15:0] format_display(
        input logic [15:0] val,
        input logic        blank_lz,
        input logic        phase_on
    );
        logic [15:0] r;
        r = val;
        if (!phase_on) begin
            r = {4{BLANK_NIBBLE}};
        end else if (blank_lz) begin
            if (val[15:12] == 4'h0) begin
                r[15:12] = BLANK_NIBBLE;
                if (val[11:8] == 4'h0) begin
                    r[11:8] = BLANK_NIBBLE;
                    if (val[7:4] == 4'h0) begin
                        r[7:4] = BLANK_NIBBLE;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// Request/acknowledge bus between the two requesters and the arbiter.
interface seg_disp_arbiter_if;
    logic        req_a;
    logic [15:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [15:0] data_b;
    logic        ack_b;

    modport master (output req_a, data_a, req_b, data_b, input ack_a, ack_b);
    modport slave  (input req_a, data_a, req_b, data_b, output ack_a, ack_b);
endinterface

// File: rtl/seg_blink_gen.sv
// Blink phase generator: while enabled, toggles the phase every BLINK_CYCLES.
module seg_blink_gen #(
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int CNT_W        = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic phase_on
);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // Counter and phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Count while enabled, flip the phase on wrap, and restart when disabled.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Dropping the enable forces ON right away, without waiting for the register.
    assign phase_on = phase_q | ~en;

endmodule

// File: rtl/seg_disp_arbiter.sv
// Two-requester round-robin arbiter for the 4-digit seven-segment driver.
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int HOLD_CYCLES  = 25_000_000,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int CNT_W        = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seg_disp_arbiter_if.slave        bus,
    input  logic                     err_flag,
    input  logic                     blank_lz,
    output logic [3:0]               data_four,
    output logic [3:0]               data_three,
    output logic [3:0]               data_two,
    output logic [3:0]               data_one,
    output logic                     src,
    output logic                     busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic             pend_q, pend_d;         // grant decided, latch on next edge
    logic             pend_src_q, pend_src_d;
    logic             last_src_q, last_src_d; // round-robin pointer
    logic [15:0]      val_q, val_d;
    logic             shown_q, shown_d;       // something latched since reset
    logic             src_q, src_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [15:0]      disp_q, disp_d;
    logic             phase_on;
    logic             pend_req;

    seg_blink_gen #(
        .BLINK_CYCLES (BLINK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (err_flag),
        .phase_on (phase_on)
    );

    // State, arbitration and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_src_q <= SRC_A;
            last_src_q <= SRC_B;
            val_q      <= 16'h0000;
            shown_q    <= 1'b0;
            src_q      <= SRC_A;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            hold_cnt_q <= '0;
            disp_q     <= {4{BLANK_NIBBLE}};
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_src_q <= pend_src_d;
            last_src_q <= last_src_d;
            val_q      <= val_d;
            shown_q    <= shown_d;
            src_q      <= src_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            hold_cnt_q <= hold_cnt_d;
            disp_q     <= disp_d;
        end
    end

    assign pend_req = (pend_src_q == SRC_B) ? bus.req_b : bus.req_a;

    // Next state: pick a winner in IDLE, latch it one edge later, then hold.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_src_d = pend_src_q;
        last_src_d = last_src_q;
        val_d      = val_q;
        shown_d    = shown_q;
        src_d      = src_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        hold_cnt_d = hold_cnt_q;
        // Nothing is shown until the first value has been latched after reset.
        disp_d     = shown_q ? format_display(val_q, blank_lz, phase_on)
                             : {4{BLANK_NIBBLE}};
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    // A requester that dropped its req before latching is abandoned.
                    if (pend_req) begin
                        val_d      = (pend_src_q == SRC_B) ? bus.data_b : bus.data_a;
                        shown_d    = 1'b1;
                        ack_a_d    = (pend_src_q == SRC_A);
                        ack_b_d    = (pend_src_q == SRC_B);
                        src_d      = pend_src_q;
                        last_src_d = pend_src_q;
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end
                end else if (bus.req_a || bus.req_b) begin
                    pend_d = 1'b1;
                    if (bus.req_a && bus.req_b) begin
                        pend_src_d = (last_src_q == SRC_B) ? SRC_A : SRC_B;
                    end else begin
                        pend_src_d = bus.req_b ? SRC_B : SRC_A;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack_a  = ack_a_q;
    assign bus.ack_b  = ack_b_q;
    assign src        = src_q;
    assign busy       = (state_q == HOLD);
    assign data_four  = disp_q[15:12];
    assign data_three = disp_q[11:8];
    assign data_two   = disp_q[7:4];
    assign data_one   = disp_q[3:0];

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Time-shares the 4-digit seven-segment display driver between two requesters, A and B. Example requesters: the I2C EEPROM write path (address/data) and the read path (read-back data).
- Each requester submits a 16-bit value with a req/ack handshake.
- The arbiter latches the granted value and holds it on screen for a minimum time.
- It drives the driver's four nibble inputs and applies leading-zero blanking and error blinking.
- It sits between the EEPROM controller and the display driver. The driver renders nibble 4'hf as all segments off.

Parameters:
- HOLD_CYCLES, 25_000_000, minimum clk cycles a granted value stays displayed before another grant (0.5 s at 50 MHz).
- BLINK_CYCLES, 12_500_000, clk cycles per blink half-period while err_flag is high.
- CNT_W, 25, width of the hold and blink counters. Must satisfy 2^CNT_W > max(HOLD_CYCLES, BLINK_CYCLES).

Ports:
- clk  in  1  system clock; sole clock domain
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A has a value to show; held high until ack_a
- data_a  in  16  requester A value; stable while req_a is high
- ack_a  out  1  one-cycle pulse; data_a has been latched
- req_b  in  1  requester B request, same rules as A
- data_b  in  16  requester B value
- ack_b  out  1  one-cycle pulse; data_b has been latched
- err_flag  in  1  level; high makes the displayed value blink
- blank_lz  in  1  level; high enables leading-zero blanking
- data_four  out  4  most significant digit to the display driver
- data_three  out  4  digit 3
- data_two  out  4  digit 2
- data_one  out  4  least significant digit
- src  out  1  source of the displayed value: 0 = A, 1 = B
- busy  out  1  high while in HOLD

Behaviour:
- Reset values (asynchronous, applied immediately at any time, including mid-HOLD or mid-blink):
  - state IDLE; latched value 16'h0000.
  - data_four..data_one = 4'hf (blank).
  - ack_a = ack_b = 0; src = 0; busy = 0.
  - Round-robin pointer = "B last", so A wins the first contest.
  - Hold and blink counters 0; blink phase ON.
- FSM states: IDLE and HOLD.
- IDLE, no req: stay. The display keeps the last latched value.
- IDLE, req seen at edge N:
  - Grant per round-robin: if only one requester asserts, grant it. If both assert, grant the one not granted last.
  - At edge N+1: latch that requester's data; pulse its ack for exactly one cycle; update src and the pointer; clear the hold counter; enter HOLD (busy = 1).
  - At edge N+2: the new value appears on data_* (outputs registered, one cycle after latch).
- HOLD:
  - The hold counter increments each cycle. New requests are not acked and simply wait.
  - When the counter reaches HOLD_CYCLES-1, go to IDLE next cycle (busy = 0).
  - A pending req is granted from IDLE on the following edge. There is no grant directly from HOLD.
- A req still high after its ack is treated as a new request.
- A req dropped before ack is abandoned. Nothing is latched and no ack is issued.
- ack_a and ack_b are never high in the same cycle.
- Leading-zero blanking (blank_lz = 1):
  - Scan from data_four downward. Each leading nibble equal to 0 is replaced by 4'hf until the first nonzero nibble.
  - data_one is never blanked, so 16'h0000 shows only "0" on digit 1.
  - blank_lz = 0 passes nibbles unmodified.
  - A genuine hex F digit renders blank. This is accepted.
- Blink:
  - While err_flag = 1, the blink counter counts 0..BLINK_CYCLES-1 and toggles the phase on wrap.
  - During the OFF phase, all four outputs are 4'hf.
  - When err_flag falls, the counter clears and the phase forces ON within one cycle.
  - The first OFF phase begins BLINK_CYCLES cycles after err_flag rises.
- Blink and blanking do not alter the latched value; arbitration is unaffected by err_flag.

Decomposition:
- Shared package seg_disp_pkg:
  - BLANK_NIBBLE = 4'hf.
  - State enum {IDLE, HOLD}.
  - Source encoding SRC_A = 0, SRC_B = 1.
- One sub-module, seg_blink_gen: the blink counter and phase. Inputs clk, rst_n, en (= err_flag); output phase_on; parameters BLINK_CYCLES, CNT_W.
- Arbitration, hold counter and output formatting stay in the top module.

Test Plan (HOLD_CYCLES = 8, BLINK_CYCLES = 4, CNT_W = 4):
- Reset released, no req -> all data_* = 4'hf, ack_a = ack_b = 0, busy = 0.
- req_a = 1 with data_a = 16'h12A4 at edge N -> ack_a high for exactly the cycle after edge N+1; busy = 1; data_four..one = 1,2,A,4 after edge N+2; src = 0; busy falls after 8 HOLD cycles.
- req_a and req_b both high from reset, held after ack (data_a = 16'h1111, data_b = 16'h2222) -> grant order A, B, A, B. Consecutive acks are spaced 10 cycles apart (1 grant + 8 hold + 1 return to IDLE). Display alternates 1111 / 2222.
- blank_lz = 1, data_b = 16'h0030 -> outputs f,f,3,0. Then data_b = 16'h0000 -> outputs f,f,f,0.
- Value 16'h5678 shown, err_flag = 1 -> outputs alternate 5678 / ffff every 4 cycles. err_flag = 0 during an OFF phase -> 5678 restored within 1 cycle.
- rst_n pulsed low mid-HOLD with req_b pending -> outputs immediately ffff, busy = 0. After release, the pending req_b is granted via IDLE, and A would win a tie since the pointer reset to "B last".
